// File: rtl/spram_pipe_ctrl.sv
// Single-port SRAM model with valid/ready requests, byte enables, READ_LAT-deep read
// pipeline and a fill engine. Define SPRAM_PARITY_EN to store and check per-byte parity.
module spram_pipe_ctrl #(
  parameter int                   MEM_WIDTH  = 32,
  parameter int                   MEM_DEPTH  = 4096,
  parameter int                   READ_LAT   = 1,
  parameter logic [MEM_WIDTH-1:0] INIT_VALUE = '0,
  localparam int                  AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  localparam int                  NB         = MEM_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_start,
  output logic                 init_busy,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [AW-1:0]        req_addr,
  input  logic [NB-1:0]        req_be,
  input  logic [MEM_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [MEM_WIDTH-1:0] rsp_rdata,
  output logic                 rsp_perr
);

  localparam logic [0:0]    ST_INIT   = 1'b0;
  localparam logic [0:0]    ST_READY  = 1'b1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

  logic [0:0]           state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [MEM_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                 addr_ok, rd_acc, wr_acc;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [MEM_WIDTH-1:0] wr_data;
  logic [NB-1:0]        wr_be;
  logic [MEM_WIDTH-1:0] rd_word;
  logic                 rd_perr;

  logic [READ_LAT-1:0]  vld_q, vld_d;
  logic [READ_LAT-1:0]  perr_q, perr_d;
  logic [MEM_WIDTH-1:0] data_q [READ_LAT];
  logic [MEM_WIDTH-1:0] data_d [READ_LAT];

  assign init_busy = (state_q == ST_INIT);
  assign req_ready = (state_q == ST_READY);
  assign addr_ok   = ({1'b0, req_addr} < (AW + 1)'(MEM_DEPTH));
  assign rd_acc    = req_valid & req_ready & ~req_we;
  assign wr_acc    = req_valid & req_ready & req_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end else if (init_start) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
  end

  // The fill engine and the request port share the one write port; INIT owns it outright.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = req_addr;
    wr_data = req_wdata;
    wr_be   = req_be;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_data = INIT_VALUE;
      wr_be   = '1;
    end else if (wr_acc && addr_ok) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (addr_ok) rd_word = mem_q[req_addr];
  end

`ifdef SPRAM_PARITY_EN
  logic [NB-1:0] par_q [MEM_DEPTH];
  logic [NB-1:0] wr_par, rd_par_calc, rd_par_stored;

  for (genvar gi = 0; gi < NB; gi++) begin : g_par
    assign wr_par[gi]      = ^wr_data[gi*8 +: 8];
    assign rd_par_calc[gi] = ^rd_word[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) par_q[wr_addr][b] <= wr_par[b];
      end
    end
  end

  always_comb begin
    rd_par_stored = '0;
    if (addr_ok) rd_par_stored = par_q[req_addr];
  end

  assign rd_perr = addr_ok & (|(rd_par_stored ^ rd_par_calc));
`else
  assign rd_perr = 1'b0;
`endif

  // Stage 0 captures the array at acceptance; later stages only advance behind a valid
  // so the last stage holds its data between responses.
  always_comb begin
    vld_d     = '0;
    perr_d    = '0;
    data_d    = data_q;
    vld_d[0]  = rd_acc;
    perr_d[0] = rd_acc & rd_perr;
    if (rd_acc) data_d[0] = rd_word;
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      perr_d[i] = perr_q[i-1];
      if (vld_q[i-1]) data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      vld_q   <= '0;
      perr_q  <= '0;
      for (int i = 0; i < READ_LAT; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      perr_q  <= perr_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid = vld_q[READ_LAT-1];
  assign rsp_rdata = data_q[READ_LAT-1];
`ifdef SPRAM_PARITY_EN
  assign rsp_perr  = perr_q[READ_LAT-1];
`else
  assign rsp_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_spram_pipe_ctrl.sv
// Directed bench for spram_pipe_ctrl: depth 12, read latency 3, fill value A5A5A5A5.
module tb_spram_pipe_ctrl;

  localparam int          DEPTH = 12;
  localparam int          LAT   = 3;
  localparam logic [31:0] INITV = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_start = 1'b0;
  logic        init_busy;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_perr;

  int n_checks = 0;
  int n_fail   = 0;

  spram_pipe_ctrl #(
    .MEM_WIDTH (32),
    .MEM_DEPTH (DEPTH),
    .READ_LAT  (LAT),
    .INIT_VALUE(INITV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_start(init_start),
    .init_busy (init_busy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_perr  (rsp_perr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data; req_be = be;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    $display("write addr %0d data %h be %b", addr, data, be);
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [31:0] exp, input logic exp_perr);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    $display("read addr %0d data %h perr %0d latency %0d", addr, rsp_rdata, rsp_perr, n);
    check("rd_latency", 32'(n), 32'(LAT));
    check("rd_data", rsp_rdata, exp);
    check("rd_perr", {31'b0, rsp_perr}, {31'b0, exp_perr});
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (init_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    $display("init done after %0d cycles", n);
    check(tag, 32'(n), 32'(DEPTH));
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int busy_cnt, vcnt, rsp_n;
    logic [31:0] rsp_d;

    // Reset values
    #12;
    check("rst_init_busy", {31'b0, init_busy}, 32'd1);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_perr", {31'b0, rsp_perr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("init_cycles");

    for (int a = 0; a < DEPTH; a++) do_read(4'(a), INITV, 1'b0);

    // Byte enables 0101 over A5A5A5A5, then a be=0 no-op
    do_write(4'd5, 32'h11223344, 4'b0101);
    do_read(4'd5, 32'hA522A544, 1'b0);
    do_write(4'd5, 32'hFFFFFFFF, 4'b0000);
    do_read(4'd5, 32'hA522A544, 1'b0);

    // Back-to-back reads after writes of 10,20,30
    do_write(4'd1, 32'd10, 4'hF);
    do_write(4'd2, 32'd20, 4'hF);
    do_write(4'd3, 32'd30, 4'hF);
    @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd1;
    @(negedge clk); req_addr = 4'd2;
    @(negedge clk); req_addr = 4'd3;
    @(negedge clk); req_valid = 1'b0;
    check("b2b_v0", {31'b0, rsp_valid}, 32'd1);
    check("b2b_d0", rsp_rdata, 32'd10);
    @(negedge clk);
    check("b2b_v1", {31'b0, rsp_valid}, 32'd1);
    check("b2b_d1", rsp_rdata, 32'd20);
    @(negedge clk);
    check("b2b_v2", {31'b0, rsp_valid}, 32'd1);
    check("b2b_d2", rsp_rdata, 32'd30);
    @(negedge clk);
    $display("back-to-back reads 1,2,3 done, after: valid %0d data %h", rsp_valid, rsp_rdata);
    check("b2b_end_valid", {31'b0, rsp_valid}, 32'd0);
    check("b2b_hold_data", rsp_rdata, 32'd30);

    // Read-after-write on consecutive cycles
    @(negedge clk); req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd4; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
    @(negedge clk); req_we = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    $display("raw addr 4 data %h valid %0d", rsp_rdata, rsp_valid);
    check("raw_valid", {31'b0, rsp_valid}, 32'd1);
    check("raw_data", rsp_rdata, 32'hDEADBEEF);

    // Out-of-range accesses
    do_write(4'd13, 32'hFFFFFFFF, 4'hF);
    do_read(4'd13, 32'd0, 1'b0);
    do_read(4'd12, 32'd0, 1'b0);
    do_read(4'd1, 32'd10, 1'b0);

    // Read accepted with init_start; a second init_start mid-fill is ignored
    do_write(4'd6, 32'h12345678, 4'hF);
    @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd6; init_start = 1'b1;
    @(negedge clk); req_valid = 1'b0; init_start = 1'b0;
    check("istart_busy", {31'b0, init_busy}, 32'd1);
    check("istart_ready", {31'b0, req_ready}, 32'd0);
    busy_cnt = 0; vcnt = 0; rsp_n = 0; rsp_d = '0;
    for (int n = 1; n <= 20; n++) begin
      if (init_busy) busy_cnt++;
      if (rsp_valid) begin vcnt++; rsp_n = n; rsp_d = rsp_rdata; end
      init_start = (n == 5);
      @(negedge clk);
    end
    init_start = 1'b0;
    $display("init during read: rsp at %0d data %h busy %0d cycles", rsp_n, rsp_d, busy_cnt);
    check("istart_rsp_cnt", 32'(vcnt), 32'd1);
    check("istart_rsp_lat", 32'(rsp_n), 32'(LAT));
    check("istart_rsp_data", rsp_d, 32'h12345678);
    check("istart_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    check("istart_ready_after", {31'b0, req_ready}, 32'd1);
    do_read(4'd6, INITV, 1'b0);
    do_read(4'd5, INITV, 1'b0);

    // Reset mid-read drops the response and restarts the fill
    @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'b0, rsp_valid}, 32'd0);
    check("mrst_busy", {31'b0, init_busy}, 32'd1);
    check("mrst_ready", {31'b0, req_ready}, 32'd0);
    vcnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (rsp_valid) vcnt++;
    end
    check("mrst_no_rsp", 32'(vcnt), 32'd0);
    rst_n = 1'b1;
    $display("mid-operation reset released");
    count_busy("mrst_init_cycles");
    do_read(4'd2, INITV, 1'b0);

`ifdef SPRAM_PARITY_EN
    @(negedge clk);
    dut.mem_q[7] = dut.mem_q[7] ^ 32'h0000_0001;
    do_read(4'd7, INITV ^ 32'h0000_0001, 1'b1);
    do_read(4'd8, INITV, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
